univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 162 ++++++++++++++++
 tb/tb_univ_shift_reg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/arith/clear on the falling clock edge, with optional counted bursts.
// Build option: define UNIV_SHIFT_REG_PARITY_EN to add a registered even-parity output of q.
//
// state | meaning
// IDLE  | mode applied directly each edge; start latches mode and count
// RUN   | latched mode applied once per edge until the count runs out
// DONE  | one-cycle completion pulse, then back to IDLE
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNTW-1:0]  shift_cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    output logic             parity,
`endif
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNTW-1:0] CNT_ZERO = '0;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_q;
    logic             op_sout;

    // The datapath sees the latched mode during a burst and the live mode otherwise.
    always_comb begin
        op_mode = (state_q == ST_RUN) ? mode_q : mode;
        op_q    = q_q;
        op_sout = sout_q;
        case (op_mode)
            MODE_HOLD: begin
                op_q    = q_q;
                op_sout = sout_q;
            end
            MODE_LOAD: op_q = d;
            MODE_SHL: begin
                op_q    = {q_q[WIDTH-2:0], sin};
                op_sout = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                op_q    = {sin, q_q[WIDTH-1:1]};
                op_sout = q_q[0];
            end
            MODE_ROL: begin
                op_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                op_sout = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                op_q    = {q_q[0], q_q[WIDTH-1:1]};
                op_sout = q_q[0];
            end
            MODE_ASR: begin
                op_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                op_sout = q_q[0];
            end
            MODE_CLR: op_q = '0;
            default: begin
                op_q    = q_q;
                op_sout = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    cnt_d   = shift_cnt;
                    state_d = (shift_cnt == CNT_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    q_d    = op_q;
                    sout_d = op_sout;
                end
            end
            ST_RUN: begin
                q_d    = op_q;
                sout_d = op_sout;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^q_d;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNTW=4): directed scenarios plus randomized direct ops,
// with expected {q,sout,busy,done} pushed to a scoreboard queue when driven and popped after each falling edge.
module tb_univ_shift_reg;

    typedef struct packed {
        logic [2:0]  m;
        logic [7:0]  dv;
        logic        s;
        logic        st;
        logic [3:0]  c;
        logic [10:0] e;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] shift_cnt;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic       parity;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [10:0] sb[$];
    logic [10:0] exp_v;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .CNTW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .d         (d),
        .sin       (sin),
        .start     (start),
        .shift_cnt (shift_cnt),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
`ifdef UNIV_SHIFT_REG_PARITY_EN
        .parity    (parity),
`endif
        .done      (done)
    );

    function automatic step_t mk(input logic [2:0] m, input logic [7:0] dv, input logic s,
                                 input logic st, input logic [3:0] c, input logic [7:0] eq,
                                 input logic es, input logic eb, input logic ed);
        mk = {m, dv, s, st, c, eq, es, eb, ed};
    endfunction

    // Reference behaviour of one direct operation: returns {sout, q}.
    function automatic logic [8:0] ref_op(input logic [2:0] m, input logic [7:0] cur,
                                          input logic s, input logic so, input logic [7:0] dv);
        logic [7:0] nq;
        logic       ns;
        nq = cur;
        ns = so;
        case (m)
            3'd1: nq = dv;
            3'd2: begin nq = (cur << 1) | {7'd0, s}; ns = cur[7]; end
            3'd3: begin nq = (cur >> 1) | {s, 7'd0}; ns = cur[0]; end
            3'd4: begin nq = (cur << 1) | (cur >> 7); ns = cur[7]; end
            3'd5: begin nq = (cur >> 1) | (cur << 7); ns = cur[0]; end
            3'd6: begin nq = 8'($signed(cur) >>> 1); ns = cur[0]; end
            3'd7: nq = 8'h00;
            default: nq = cur;
        endcase
        return {ns, nq};
    endfunction

    task automatic drive(input step_t s);
        mode      = s.m;
        d         = s.dv;
        sin       = s.s;
        start     = s.st;
        shift_cnt = s.c;
        sb.push_back(s.e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 3'd0; d = 8'h00; sin = 1'b0; start = 1'b0; shift_cnt = 4'd0;
        #3;
        checks++;
        if ({q, sout, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset {q,sout,busy,done} got %h want %h", {q, sout, busy, done}, 11'd0);
        end
        @(posedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_shift();
        step_t arr[$];
        arr.push_back(mk(3'd1, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd1, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd3, 8'h00, 1'b1, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd2, 8'h00, 1'b1, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd0, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd7, 8'hFF, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0));
        foreach (arr[i]) begin
            drive(arr[i]);
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL load_shift step %0d {q,sout,busy,done} got %h want %h", i, {q, sout, busy, done}, exp_v);
            end
        end
    endtask

    // Rotate-left burst of 3; live mode/start during RUN and DONE must be ignored.
    task automatic test_burst();
        step_t arr[$];
        arr.push_back(mk(3'd1, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd4, 8'h00, 1'b0, 1'b1, 4'd3, 8'h01, 1'b1, 1'b1, 1'b0));
        arr.push_back(mk(3'd7, 8'h00, 1'b1, 1'b1, 4'd5, 8'h02, 1'b0, 1'b1, 1'b0));
        arr.push_back(mk(3'd7, 8'h00, 1'b1, 1'b1, 4'd5, 8'h04, 1'b0, 1'b1, 1'b0));
        arr.push_back(mk(3'd7, 8'h00, 1'b1, 1'b1, 4'd5, 8'h08, 1'b0, 1'b0, 1'b1));
        arr.push_back(mk(3'd7, 8'h00, 1'b1, 1'b1, 4'd5, 8'h08, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h08, 1'b0, 1'b0, 1'b0));
        foreach (arr[i]) begin
            drive(arr[i]);
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL burst step %0d {q,sout,busy,done} got %h want %h", i, {q, sout, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_zero_cnt_and_arith();
        step_t arr[$];
        arr.push_back(mk(3'd2, 8'h00, 1'b1, 1'b1, 4'd0, 8'h08, 1'b0, 1'b0, 1'b1));
        arr.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h08, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd1, 8'h80, 1'b0, 1'b0, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd6, 8'h00, 1'b1, 1'b0, 4'd0, 8'hC0, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd6, 8'h00, 1'b1, 1'b0, 4'd0, 8'hE0, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd6, 8'h00, 1'b1, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd1, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0));
        arr.push_back(mk(3'd6, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0));
        foreach (arr[i]) begin
            drive(arr[i]);
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL zero_cnt_arith step %0d {q,sout,busy,done} got %h want %h", i, {q, sout, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        step_t arr[$];
        step_t post[$];
        arr.push_back(mk(3'd1, 8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0));
        arr.push_back(mk(3'd4, 8'h00, 1'b0, 1'b1, 4'd10, 8'h01, 1'b1, 1'b1, 1'b0));
        arr.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h02, 1'b0, 1'b1, 1'b0));
        arr.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h04, 1'b0, 1'b1, 1'b0));
        arr.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h08, 1'b0, 1'b1, 1'b0));
        foreach (arr[i]) begin
            drive(arr[i]);
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL mid_burst step %0d {q,sout,busy,done} got %h want %h", i, {q, sout, busy, done}, exp_v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({q, sout, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL mid_burst async_reset got %h want %h", {q, sout, busy, done}, 11'd0);
        end
        @(negedge clk); #1;
        checks++;
        if ({q, sout, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL mid_burst held_reset got %h want %h", {q, sout, busy, done}, 11'd0);
        end
        @(posedge clk);
        rst_n = 1'b1;
        post.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
        post.push_back(mk(3'd1, 8'h03, 1'b0, 1'b0, 4'd0, 8'h03, 1'b0, 1'b0, 1'b0));
        post.push_back(mk(3'd5, 8'h00, 1'b0, 1'b1, 4'd2, 8'h03, 1'b0, 1'b1, 1'b0));
        post.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b1, 1'b0));
        post.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b1));
        post.push_back(mk(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0));
        foreach (post[i]) begin
            drive(post[i]);
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL after_reset step %0d {q,sout,busy,done} got %h want %h", i, {q, sout, busy, done}, exp_v);
            end
        end
    endtask

`ifdef UNIV_SHIFT_REG_PARITY_EN
    task automatic test_parity();
        logic [2:0] pm[3] = '{3'd1, 3'd2, 3'd1};
        logic [7:0] pd[3] = '{8'h07, 8'h00, 8'h03};
        logic       pe[3] = '{1'b1, 1'b1, 1'b0};
        logic       pq[$];
        logic       pexp;
        for (int i = 0; i < 3; i++) begin
            mode = pm[i]; d = pd[i]; sin = 1'b0; start = 1'b0; shift_cnt = 4'd0;
            pq.push_back(pe[i]);
            @(negedge clk); #1;
            pexp = pq.pop_front();
            checks++;
            if (parity !== pexp) begin
                errors++;
                $display("FAIL parity step %0d got %b want %b (q=%h)", i, parity, pexp, q);
            end
        end
    endtask
`endif

    task automatic test_random_ops();
        logic [7:0] m_q;
        logic       m_so;
        logic [8:0] r;
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        rst_n = 1'b1;
        m_q  = 8'h00;
        m_so = 1'b0;
        for (int i = 0; i < 300; i++) begin
            mode      = 3'($urandom_range(0, 7));
            d         = 8'($urandom);
            sin       = 1'($urandom);
            start     = 1'b0;
            shift_cnt = 4'($urandom);
            r = ref_op(mode, m_q, sin, m_so, d);
            m_q  = r[7:0];
            m_so = r[8];
            sb.push_back({m_q, m_so, 1'b0, 1'b0});
            @(negedge clk); #1;
            exp_v = sb.pop_front();
            checks++;
            if ({q, sout, busy, done} !== exp_v) begin
                errors++;
                $display("FAIL random step %0d mode %0d {q,sout,busy,done} got %h want %h", i, mode, {q, sout, busy, done}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_burst();
        test_zero_cnt_and_arith();
        test_reset_mid_burst();
`ifdef UNIV_SHIFT_REG_PARITY_EN
        test_parity();
`endif
        test_random_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before bench completion");
        $fatal(1);
    end

endmodule
